// File: rtl/uart_ctrl_param_pkg.sv
// uart_ctrl_param_pkg: register map, CTRL bit positions, parity encodings and FSM states.
package uart_ctrl_param_pkg;
    localparam logic [1:0] REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_CTRL = 2'd2, REG_DIV = 2'd3;
    localparam int CT_TX_EN = 0, CT_RX_EN = 1, CT_PAR = 2, CT_STOP2 = 4, CT_RX_IRQ = 5, CT_TX_IRQ = 6;
    localparam logic [1:0] PAR_EVEN = 2'b01, PAR_ODD = 2'b10;
    localparam logic [6:0] CTRL_RESET = 7'h03;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} uart_state_t;
    function automatic logic parity_on(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction
endpackage

// File: rtl/uart_ctrl_param_fifo.sv
// uart_ctrl_param_fifo: synchronous FIFO; push while full is accepted only alongside a pop.
module uart_ctrl_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int LOG_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0] wptr, rptr;
    logic push, pop;
    assign empty = count == '0;
    assign full = count == (LOG_DEPTH+1)'(DEPTH);
    assign pop = ren && !empty;
    assign push = wen && (!full || pop);
    assign rdata = mem[rptr];
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + LOG_DEPTH'(push);
            rptr <= rptr + LOG_DEPTH'(pop);
            count <= count + (LOG_DEPTH+1)'(push) - (LOG_DEPTH+1)'(pop);
        end
    end
endmodule

// File: rtl/uart_ctrl_param.sv
// uart_ctrl_param: memory-mapped UART with TX/RX FIFOs, runtime divisor, parity, stop bits and level irq.
module uart_ctrl_param
    import uart_ctrl_param_pkg::*;
#(
    parameter int DIV_DEFAULT = 868,
    parameter int FIFO_DEPTH = 32,
    parameter int LOG_DEPTH = 5,
    parameter int DATA_BITS = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_in,
    output logic        uart_out,
    output logic        irq
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    logic [6:0] ctrl;
    logic [15:0] div, div_eff;
    logic [3:0] sticky, sticky_set;
    logic [1:0] sel;
    logic wr_data, rd_data, wr_status, tx_busy, unused_bits;
    logic tx_pop, tx_empty, tx_full, rx_push, rx_empty, rx_full;
    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic [LOG_DEPTH:0] unused_tx_count, unused_rx_count;
    logic [31:0] status, rd_mux;
    uart_state_t tx_state, tx_next, rx_state, rx_next;
    logic [15:0] tx_cnt, tx_div, rx_cnt, rx_div;
    logic [DATA_BITS-1:0] tx_sh, rx_sh;
    logic [2:0] tx_bit, rx_bit;
    logic tx_tick, tx_par_en, tx_pbit, tx_two, tx_stop2, tx_line;
    logic [SYNC_STAGES-1:0] sync;
    logic rx_s, rx_prev, rx_tick, rx_par_en, rx_odd, rx_pbit, rx_start, rx_stop;
    logic frame_err_set, par_err_set;

    assign sel = addr[3:2];
    assign unused_bits = ^{addr[1:0], wdata[31:16]};
    assign wr_data = wen && sel == REG_DATA;
    assign rd_data = ren && sel == REG_DATA;
    assign wr_status = wen && sel == REG_STATUS;
    assign div_eff = div < 16'd2 ? 16'd2 : div;
    assign tx_busy = tx_state != S_IDLE;
    assign sticky_set = {wr_data && tx_full && !tx_pop, par_err_set, frame_err_set, rx_push && rx_full && !rd_data};
    assign status = {23'b0, tx_busy, sticky, rx_full, !rx_empty, tx_full, tx_empty};
    assign rd_mux = sel == REG_DATA ? {23'b0, !rx_empty, rx_empty ? 8'h00 : 8'(rx_head)} :
                    sel == REG_STATUS ? status :
                    sel == REG_CTRL ? {25'b0, ctrl} : {16'b0, div};

    uart_ctrl_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LOG_DEPTH(LOG_DEPTH)) tx_fifo (
        .clk(clk), .rst(rst), .wen(wr_data), .ren(tx_pop), .wdata(wdata[DATA_BITS-1:0]),
        .rdata(tx_head), .empty(tx_empty), .full(tx_full), .count(unused_tx_count));
    uart_ctrl_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LOG_DEPTH(LOG_DEPTH)) rx_fifo (
        .clk(clk), .rst(rst), .wen(rx_push), .ren(rd_data), .wdata(rx_sh),
        .rdata(rx_head), .empty(rx_empty), .full(rx_full), .count(unused_rx_count));

    // Sticky set is OR-ed after the W1C mask so a simultaneous set survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= CTRL_RESET;
            div <= 16'(DIV_DEFAULT);
            sticky <= '0;
            rdata <= '0;
            irq <= 1'b0;
        end else begin
            if (wen && sel == REG_CTRL) ctrl <= wdata[6:0];
            if (wen && sel == REG_DIV) div <= wdata[15:0];
            sticky <= (sticky & ~(wr_status ? wdata[7:4] : 4'b0)) | sticky_set;
            if (ren) rdata <= rd_mux;
            irq <= (ctrl[CT_RX_IRQ] && !rx_empty) || (ctrl[CT_TX_IRQ] && tx_empty && !tx_busy);
        end
    end

    assign tx_tick = tx_cnt == tx_div - 16'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            uart_out <= 1'b1;
            tx_cnt <= '0;
            {tx_div, tx_sh, tx_bit, tx_par_en, tx_pbit, tx_two, tx_stop2} <= '0;
        end else begin
            tx_state <= tx_next;
            uart_out <= tx_line;
            tx_cnt <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 16'd1;
            if (tx_pop) begin
                tx_sh <= tx_head;
                tx_div <= div_eff;
                tx_par_en <= parity_on(ctrl[CT_PAR+1:CT_PAR]);
                tx_pbit <= ^tx_head ^ (ctrl[CT_PAR+1:CT_PAR] == PAR_ODD);
                tx_two <= ctrl[CT_STOP2];
                tx_bit <= '0;
                tx_stop2 <= 1'b0;
            end
            if (tx_tick && tx_state == S_DATA) begin
                tx_sh <= tx_sh >> 1;
                tx_bit <= tx_bit + 3'd1;
            end
            if (tx_tick && tx_state == S_STOP) tx_stop2 <= 1'b1;
        end
    end
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (ctrl[CT_TX_EN] && !tx_empty) tx_next = S_START;
            S_START:  if (tx_tick) tx_next = S_DATA;
            S_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_next = tx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (tx_tick) tx_next = S_STOP;
            S_STOP:   if (tx_tick && (!tx_two || tx_stop2)) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end
    always_comb begin
        tx_pop = tx_state == S_IDLE && ctrl[CT_TX_EN] && !tx_empty;
        tx_line = tx_state == S_START ? 1'b0 : tx_state == S_DATA ? tx_sh[0] :
                  tx_state == S_PARITY ? tx_pbit : 1'b1;
    end

    assign rx_s = sync[SYNC_STAGES-1];
    assign rx_tick = rx_cnt == (rx_state == S_START ? {1'b0, rx_div[15:1]} : rx_div) - 16'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            rx_prev <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt <= '0;
            {rx_div, rx_sh, rx_bit, rx_par_en, rx_odd, rx_pbit} <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], uart_in};
            rx_prev <= rx_s;
            rx_state <= rx_next;
            rx_cnt <= (rx_state == S_IDLE || rx_state == S_WAIT || rx_tick) ? '0 : rx_cnt + 16'd1;
            if (rx_start) begin
                rx_div <= div_eff;
                rx_par_en <= parity_on(ctrl[CT_PAR+1:CT_PAR]);
                rx_odd <= ctrl[CT_PAR+1:CT_PAR] == PAR_ODD;
                rx_bit <= '0;
            end
            if (rx_tick && rx_state == S_DATA) begin
                rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                rx_bit <= rx_bit + 3'd1;
            end
            if (rx_tick && rx_state == S_PARITY) rx_pbit <= rx_s;
        end
    end
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_prev && !rx_s) rx_next = S_START;
            S_START:  if (rx_tick) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_next = rx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (rx_tick) rx_next = S_STOP;
            S_STOP:   if (rx_tick) rx_next = rx_s ? S_IDLE : S_WAIT;
            default:  if (rx_s) rx_next = S_IDLE;
        endcase
        if (!ctrl[CT_RX_EN]) rx_next = S_IDLE;
    end
    always_comb begin
        rx_start = rx_state == S_IDLE && ctrl[CT_RX_EN] && rx_prev && !rx_s;
        rx_stop = ctrl[CT_RX_EN] && rx_state == S_STOP && rx_tick;
        rx_push = rx_stop && rx_s;
        frame_err_set = rx_stop && !rx_s;
        par_err_set = rx_push && rx_par_en && (rx_pbit != (^rx_sh ^ rx_odd));
    end
endmodule
